ysyx_23060184_pipe_skid_reg: RTL

YSYX_23060184_PIPE_SKID_REG -- requirements
Module: ysyx_23060184_pipe_skid_reg

---
 rtl/ysyx_23060184_pipe_pkg.sv | 19 +
 rtl/ysyx_23060184_pipe_slot.sv | 22 ++
 rtl/ysyx_23060184_pipe_skid_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/ysyx_23060184_pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy state
// encoding, slot indices and the canonical NOP instruction used for bubbles.
package ysyx_23060184_pipe_pkg;

    // The encoding doubles as the occupancy count, so keep it numeric.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int NUM_SLOTS = 2;
    localparam int SLOT_MAIN = 0;
    localparam int SLOT_SKID = 1;

endpackage

// File: rtl/ysyx_23060184_pipe_slot.sv
// One payload register of a skid stage: loads on enable, resets to the bubble.
module ysyx_23060184_pipe_slot #(
    parameter int                   PAYLOAD_W = 96,
    parameter logic [PAYLOAD_W-1:0] BUBBLE    = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] d,
    output logic [PAYLOAD_W-1:0] q
);

    // Payload capture; contents are only ever replaced by a load or reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_23060184_pipe_skid_reg.sv
// Two-entry skid pipeline register with stall and flush. in_ready depends
// only on local state and stall, so no combinational path runs from
// out_ready back to in_ready; the skid slot absorbs the extra entry.
module ysyx_23060184_pipe_skid_reg
    import ysyx_23060184_pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W = 96,
    parameter logic [PAYLOAD_W-1:0] BUBBLE    = {INST_NOP, 64'h0},
    parameter int                   CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 stall,
    input  logic                 flush,
    output logic [CNT_W-1:0]     occupancy
);

    pipe_state_e state_reg;
    pipe_state_e state_next;

    logic                 do_accept;
    logic                 do_release;
    logic [NUM_SLOTS-1:0] slot_load;
    logic [PAYLOAD_W-1:0] slot_d [NUM_SLOTS];
    logic [PAYLOAD_W-1:0] slot_q [NUM_SLOTS];

    assign in_ready   = (state_reg != ST_FULL) & ~stall;
    assign out_valid  = (state_reg != ST_EMPTY) & ~stall & ~flush;
    assign out_data   = out_valid ? slot_q[SLOT_MAIN] : BUBBLE;
    assign occupancy  = CNT_W'(state_reg);

    // Flush masks accept; stall already masks both via in_ready/out_valid.
    assign do_accept  = in_valid & in_ready & ~flush;
    assign do_release = out_valid & out_ready;

    // When FULL, the head refills from the skid slot; otherwise from upstream.
    assign slot_d[SLOT_MAIN] = (state_reg == ST_FULL) ? slot_q[SLOT_SKID] : in_data;
    assign slot_d[SLOT_SKID] = in_data;

    // Next state and slot load enables; flush clears only the valid state.
    always_comb begin
        state_next = state_reg;
        slot_load  = '0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (do_accept) begin
                        state_next           = ST_ONE;
                        slot_load[SLOT_MAIN] = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (do_accept && do_release) begin
                        slot_load[SLOT_MAIN] = 1'b1;
                    end else if (do_accept) begin
                        state_next           = ST_FULL;
                        slot_load[SLOT_SKID] = 1'b1;
                    end else if (do_release) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (do_release) begin
                        state_next           = ST_ONE;
                        slot_load[SLOT_MAIN] = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            ysyx_23060184_pipe_slot #(
                .PAYLOAD_W (PAYLOAD_W),
                .BUBBLE    (BUBBLE)
            ) u_slot (
                .clk  (clk),
                .rstn (rstn),
                .load (slot_load[gi]),
                .d    (slot_d[gi]),
                .q    (slot_q[gi])
            );
        end
    endgenerate

endmodule
